// File: rtl/sr_stack.sv
// Status-register save/restore stack: LIFO of SR snapshots taken on
// call/interrupt entry and replayed to the SR set input on return.
module sr_stack #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       SRIn,
    input  logic             Push,
    input  logic             Pop,
    output logic             RestoreValid,
    output logic [7:0]       RestoreData,
    output logic             Full,
    output logic             Empty,
    output logic [PTR_W:0]   Count,
    output logic             Overflow,
    output logic             Underflow
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;

    assign Full    = (Count == (PTR_W+1)'(DEPTH));
    assign Empty   = (Count == '0);
    assign wr_idx  = PTR_W'(Count);
    assign top_idx = PTR_W'(Count - (PTR_W+1)'(1));

    // Storage carries no reset; slots at or above Count are never read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (Push && !Pop && !Full)
                mem[wr_idx] <= SRIn;
            else if (Push && Pop && !Empty)
                mem[top_idx] <= SRIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RestoreValid <= 1'b0;
            RestoreData  <= 8'h00;
            Count        <= '0;
            Overflow     <= 1'b0;
            Underflow    <= 1'b0;
        end else begin
            RestoreValid <= 1'b0;
            unique case ({Push, Pop})
                2'b10: begin
                    if (Full)
                        Overflow <= 1'b1;
                    else
                        Count <= Count + (PTR_W+1)'(1);
                end
                2'b01: begin
                    if (Empty) begin
                        Underflow <= 1'b1;
                    end else begin
                        RestoreData  <= mem[top_idx];
                        RestoreValid <= 1'b1;
                        Count        <= Count - (PTR_W+1)'(1);
                    end
                end
                2'b11: begin
                    // Swap when occupied, straight pass-through when empty.
                    RestoreValid <= 1'b1;
                    RestoreData  <= Empty ? SRIn : mem[top_idx];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_stack.sv
// Bench for sr_stack: directed plan plus random traffic against a
// queue-based LIFO model, with a scoreboard for restore pulses.
module tb_sr_stack;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     SRIn = 8'h00;
    logic           Push = 1'b0;
    logic           Pop = 1'b0;
    logic           RestoreValid;
    logic [7:0]     RestoreData;
    logic           Full;
    logic           Empty;
    logic [PTR_W:0] Count;
    logic           Overflow;
    logic           Underflow;

    sr_stack #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk),
        .rst(rst),
        .SRIn(SRIn),
        .Push(Push),
        .Pop(Pop),
        .RestoreValid(RestoreValid),
        .RestoreData(RestoreData),
        .Full(Full),
        .Empty(Empty),
        .Count(Count),
        .Overflow(Overflow),
        .Underflow(Underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] stack[$];
    logic [7:0] m_rd;
    logic       m_ovf;
    logic       m_unf;
    logic       m_v;
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
    endtask

    // Monitor: every restore pulse must match the oldest expected one,
    // arriving exactly one cycle after the pop that produced it.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            chk("missed_restore", 0, 1);
            void'(exp_q.pop_front());
        end
        if (RestoreValid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_restore", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("restore_data", RestoreData, e.d);
                chk("restore_cycle", cyc, e.c);
            end
        end
    end

    task automatic step(input logic pu, input logic po,
                        input logic [7:0] d, input logic r);
        Push = pu;
        Pop  = po;
        SRIn = d;
        rst  = r;
        m_v  = 1'b0;
        if (r) begin
            stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rd  = 8'h00;
        end else if (pu && !po) begin
            if (stack.size() == DEPTH) m_ovf = 1'b1;
            else stack.push_back(d);
        end else if (po && !pu) begin
            if (stack.size() == 0) begin
                m_unf = 1'b1;
            end else begin
                m_rd = stack.pop_back();
                m_v  = 1'b1;
            end
        end else if (po && pu) begin
            m_v = 1'b1;
            if (stack.size() == 0) begin
                m_rd = d;
            end else begin
                m_rd = stack[stack.size()-1];
                stack[stack.size()-1] = d;
            end
        end
        if (m_v) exp_q.push_back('{d: m_rd, c: cyc + 1});
        @(posedge clk);
        #1;
        chk("count", Count, stack.size());
        chk("empty", Empty, stack.size() == 0);
        chk("full", Full, stack.size() == DEPTH);
        chk("overflow", Overflow, m_ovf);
        chk("underflow", Underflow, m_unf);
        chk("restore_data_held", RestoreData, m_rd);
        chk("restore_valid", RestoreValid, m_v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        m_rd = 8'h00; m_ovf = 1'b0; m_unf = 1'b0; m_v = 1'b0;
        // Reset held two cycles with a push that must be ignored
        step(1'b1, 1'b0, 8'hAA, 1'b1);
        step(1'b1, 1'b0, 8'hAA, 1'b1);
        // LIFO order, back-to-back pops
        step(1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b1, 1'b0, 8'h33, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        idle(1);
        // Fill, overflow, drain
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        // Underflow stays sticky
        step(1'b0, 1'b1, 8'h00, 1'b0);
        idle(5);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        // Swap
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        step(1'b1, 1'b1, 8'hC3, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        // Pass-through on empty, then reset mid-operation
        step(1'b1, 1'b1, 8'h7E, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        // Swap while full must not flag overflow
        step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic pu;
            logic po;
            r  = ($urandom_range(63) == 0);
            pu = ($urandom_range(99) < 50);
            po = ($urandom_range(99) < 45);
            step(pu, po, 8'($urandom), r);
        end
        idle(3);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
